product_bcd_convert: RTL and testbench

//  Downstream stage of the shift-add multiplier: takes the 16-bit product, converts it

---
 rtl/product_bcd_convert_pkg.sv | 13 +
 rtl/product_bcd_convert_bcd_digit_adj.sv | 14 +
 rtl/product_bcd_convert.sv | 101 ++++++++++
 tb/tb_product_bcd_convert.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/product_bcd_convert_pkg.sv
// rtl/product_bcd_convert_pkg.sv - shared widths and state encoding for the product BCD converter
package product_bcd_convert_pkg;

    // Default binary width and digit count; 10**5 > 2**16-1 so five digits cover the product
    localparam int BIN_W      = 16;
    localparam int BCD_DIGITS = 5;
    localparam int NIB_W      = 4;

    // Two-state controller encoding
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_CONV = 1'b1;

endpackage

// File: rtl/product_bcd_convert_bcd_digit_adj.sv
// rtl/product_bcd_convert_bcd_digit_adj.sv - add-3 correction for one BCD nibble ahead of a shift
module bcd_digit_adj
    import product_bcd_convert_pkg::*;
(
    input  logic [NIB_W-1:0] nibble,
    output logic [NIB_W-1:0] adjusted
);

    // A nibble of 5..9 would become 10..18 after doubling; pre-adding 3 carries it into the next digit
    always_comb begin
        adjusted = (nibble >= NIB_W'(5)) ? nibble + NIB_W'(3) : nibble;
    end

endmodule

// File: rtl/product_bcd_convert.sv
// rtl/product_bcd_convert.sv - sequential shift-add-3 binary to packed BCD with leading-zero mask
module product_bcd_convert
    import product_bcd_convert_pkg::*;
#(
    parameter int W      = BIN_W,
    parameter int DIGITS = BCD_DIGITS
) (
    input  logic                    clk,
    input  logic                    clr,
    input  logic                    in_valid,
    input  logic [W-1:0]            in_data,
    output logic                    in_ready,
    output logic                    out_valid,
    output logic [NIB_W*DIGITS-1:0] out_bcd,
    output logic [DIGITS-1:0]       out_digit_en
);

    localparam int CW    = $clog2(W + 1);
    localparam int BCD_W = NIB_W * DIGITS;

    logic [0:0]       state;
    logic [CW-1:0]    count;
    logic [W-1:0]     bin_sh;
    logic [BCD_W-1:0] bcd_sh;
    logic [BCD_W-1:0] bcd_adj;
    logic [BCD_W-1:0] bcd_next;
    logic [W-1:0]     bin_next;
    logic [DIGITS-1:0] mask_next;
    logic             unused_carry;

    genvar g;
    generate
        for (g = 0; g < DIGITS; g++) begin : g_adj
            bcd_digit_adj u_adj (
                .nibble   (bcd_sh[g*NIB_W +: NIB_W]),
                .adjusted (bcd_adj[g*NIB_W +: NIB_W])
            );
        end
    endgenerate

    // The top digit's adjusted MSB would shift out; with 10**DIGITS > 2**W-1 it is never set
    assign unused_carry = bcd_adj[BCD_W-1];

    // One shift step of {bcd, bin} after the add-3 correction
    always_comb begin
        bcd_next = {bcd_adj[BCD_W-2:0], bin_sh[W-1]};
        bin_next = {bin_sh[W-2:0], 1'b0};
    end

    // Leading-zero mask: a digit shows once it or any more significant digit is nonzero
    always_comb begin
        logic seen;
        seen      = 1'b0;
        mask_next = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            seen         = seen | (bcd_next[i*NIB_W +: NIB_W] != '0);
            mask_next[i] = seen;
        end
        mask_next[0] = 1'b1;
    end

    assign in_ready = (state == ST_IDLE);

    // Controller, shift registers and held output registers
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state        <= ST_IDLE;
            count        <= '0;
            bin_sh       <= '0;
            bcd_sh       <= '0;
            out_valid    <= 1'b0;
            out_bcd      <= '0;
            out_digit_en <= DIGITS'(1);
        end else begin
            out_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        bin_sh <= in_data;
                        bcd_sh <= '0;
                        count  <= '0;
                        state  <= ST_CONV;
                    end
                end
                ST_CONV: begin
                    bcd_sh <= bcd_next;
                    bin_sh <= bin_next;
                    count  <= count + CW'(1);
                    if (count == CW'(W - 1)) begin
                        out_bcd      <= bcd_next;
                        out_digit_en <= mask_next;
                        out_valid    <= 1'b1;
                        state        <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_product_bcd_convert.sv
// tb/tb_product_bcd_convert.sv - self-checking bench for product_bcd_convert
module tb_product_bcd_convert;

    logic        clk = 1'b0;
    logic        clr;
    logic        in_valid;
    logic [15:0] in_data;
    logic        in_ready;
    logic        out_valid;
    logic [19:0] out_bcd;
    logic [4:0]  out_digit_en;

    int checks = 0;
    int errors = 0;

    logic [19:0] held_bcd;
    logic [4:0]  held_mask;

    product_bcd_convert dut (
        .clk          (clk),
        .clr          (clr),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .out_valid    (out_valid),
        .out_bcd      (out_bcd),
        .out_digit_en (out_digit_en)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [19:0] ref_bcd(int v);
        logic [19:0] r;
        int p;
        r = '0;
        p = 1;
        for (int i = 0; i < 5; i++) begin
            r[i*4 +: 4] = 4'((v / p) % 10);
            p = p * 10;
        end
        return r;
    endfunction

    function automatic logic [4:0] ref_mask(int v);
        logic [4:0] m;
        int p;
        m = '0;
        p = 1;
        for (int i = 0; i < 5; i++) begin
            m[i] = (i == 0) || (v >= p);
            p = p * 10;
        end
        return m;
    endfunction

    // Accept v, wait for completion, return in the out_valid cycle
    task automatic do_convert(input logic [15:0] v, input bit hold, input string tag);
        int lat;
        int lows;
        bit got;
        bit held_ok;
        lat = 0;
        lows = 0;
        got = 0;
        held_ok = 1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s ready_before_accept got %b want 1", tag, in_ready);
        end
        in_valid = 1'b1;
        in_data  = v;
        tick();
        if (!hold) in_valid = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            if (in_ready === 1'b0) lows++;
            if (out_valid !== 1'b0 || out_bcd !== held_bcd || out_digit_en !== held_mask) held_ok = 0;
            if (hold) in_data = 16'($urandom);
            tick();
            lat = n;
            if (out_valid === 1'b1) begin
                got = 1;
                break;
            end
        end
        in_valid = 1'b0;
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL %s timeout no out_valid within 40 clocks", tag);
        end
        checks++;
        if (lat != 16) begin
            errors++;
            $display("FAIL %s latency got %0d want 16", tag, lat);
        end
        checks++;
        if (lows != 16) begin
            errors++;
            $display("FAIL %s ready_low_cycles got %0d want 16", tag, lows);
        end
        checks++;
        if (!held_ok) begin
            errors++;
            $display("FAIL %s outputs_changed_during_conv held %h/%b", tag, held_bcd, held_mask);
        end
        checks++;
        if (out_bcd !== ref_bcd(int'(v))) begin
            errors++;
            $display("FAIL %s out_bcd got %h want %h (in %0d)", tag, out_bcd, ref_bcd(int'(v)), v);
        end
        checks++;
        if (out_digit_en !== ref_mask(int'(v))) begin
            errors++;
            $display("FAIL %s out_digit_en got %b want %b (in %0d)", tag, out_digit_en, ref_mask(int'(v)), v);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s ready_in_done_cycle got %b want 1", tag, in_ready);
        end
        held_bcd  = ref_bcd(int'(v));
        held_mask = ref_mask(int'(v));
    endtask

    // One clock after completion with no new accept: pulse gone, outputs held
    task automatic check_pulse_end(input string tag);
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s pulse_width out_valid got %b want 0", tag, out_valid);
        end
        checks++;
        if (out_bcd !== held_bcd || out_digit_en !== held_mask) begin
            errors++;
            $display("FAIL %s hold_after_pulse got %h/%b want %h/%b", tag, out_bcd, out_digit_en, held_bcd, held_mask);
        end
    endtask

    task automatic test_reset();
        clr = 1'b1;
        in_valid = 1'b0;
        in_data = '0;
        tick();
        tick();
        clr = 1'b0;
        tick();
        held_bcd = '0;
        held_mask = 5'b00001;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_handshake got ready=%b valid=%b want 1/0", in_ready, out_valid);
        end
        checks++;
        if (out_bcd !== 20'h00000 || out_digit_en !== 5'b00001) begin
            errors++;
            $display("FAIL reset_outputs got %h/%b want 00000/00001", out_bcd, out_digit_en);
        end
    endtask

    task automatic test_zero();
        do_convert(16'd0, 0, "zero");
        check_pulse_end("zero");
    endtask

    task automatic test_max();
        do_convert(16'd65535, 0, "max");
        check_pulse_end("max");
    endtask

    task automatic test_back_to_back();
        do_convert(16'd65025, 0, "b2b_first");
        do_convert(16'd42, 0, "b2b_second");
        check_pulse_end("b2b_second");
    endtask

    task automatic test_hold_valid();
        do_convert(16'd9999, 1, "hold_valid");
        check_pulse_end("hold_valid");
    endtask

    task automatic test_clr_mid();
        bit seen_valid;
        in_valid = 1'b1;
        in_data  = 16'd1000;
        tick();
        in_valid = 1'b0;
        repeat (8) tick();
        #2 clr = 1'b1;
        #1;
        checks++;
        if (out_bcd !== 20'h00000 || out_digit_en !== 5'b00001 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL clr_mid_immediate got bcd=%h en=%b valid=%b ready=%b want 00000/00001/0/1",
                     out_bcd, out_digit_en, out_valid, in_ready);
        end
        #1 clr = 1'b0;
        held_bcd  = '0;
        held_mask = 5'b00001;
        seen_valid = 0;
        repeat (20) begin
            tick();
            if (out_valid !== 1'b0) seen_valid = 1;
        end
        checks++;
        if (seen_valid) begin
            errors++;
            $display("FAIL clr_mid_no_done got out_valid=1 want 0 after abort");
        end
        do_convert(16'd1000, 0, "clr_mid_retry");
        check_pulse_end("clr_mid_retry");
    endtask

    task automatic test_random();
        logic [15:0] v;
        for (int k = 0; k < 1000; k++) begin
            case ($urandom_range(0, 3))
                0: v = 16'($urandom_range(0, 99));
                1: v = 16'($urandom_range(9990, 10010));
                default: v = 16'($urandom);
            endcase
            do_convert(v, 0, "random");
            if ($urandom_range(0, 1) == 1) check_pulse_end("random");
        end
    endtask

    initial begin
        clr = 1'b1;
        in_valid = 1'b0;
        in_data = '0;
        held_bcd = '0;
        held_mask = 5'b00001;
        test_reset();
        test_zero();
        test_max();
        test_back_to_back();
        test_hold_valid();
        test_clr_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
